// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
package imem_loader_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned MEM_AW         = 11;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LEN_W          = 16;
  localparam logic [7:0]  CSUM_INIT      = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

  // States in which the loader is able to take a stream byte.
  function automatic logic takes_byte(input state_e s);
    return (s == S_LEN_LO) || (s == S_LEN_HI) || (s == S_DATA) || (s == S_CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Collects little-endian stream bytes into a 32-bit word; flags the 4th byte.
module imem_loader_byte_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_complete_c
);

  localparam int unsigned IDX_W = 2;

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] word_q, word_d;

  // Byte lane placement; index wraps to 0 after the 4th byte.
  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear_i) begin
      idx_d  = '0;
      word_d = '0;
    end else if (byte_valid_i) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_i;
      idx_d                        = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      word_q <= '0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

  assign word_complete_c = byte_valid_i && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
  assign word_o          = word_q;

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader writing the instruction SRAM and holding the core
// in reset while a load is in progress or has failed.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned WIDTH      = DATA_W,
  parameter int unsigned ADDR_WIDTH = MEM_AW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  START,
  input  logic [7:0]            IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  MEM_CEN,
  output logic                  MEM_WEN,
  output logic [ADDR_WIDTH-1:0] MEM_A,
  output logic [WIDTH-1:0]      MEM_D,
  output logic                  CORE_HOLD,
  output logic                  DONE,
  output logic                  ERROR
);

  localparam int unsigned      CNT_W     = ADDR_WIDTH + 1;
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(1) << ADDR_WIDTH;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              csum_q, csum_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    ready_q, ready_d;
  logic                    cen_q, cen_d;
  logic                    wen_q, wen_d;
  logic                    hold_q, hold_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept;
  logic                    start_evt;
  logic                    asm_valid;
  logic                    word_complete_c;
  logic [DATA_W-1:0]       asm_word;

  assign accept    = IN_VALID && ready_q;
  assign start_evt = START && ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERR));
  assign asm_valid = accept && (state_q == S_DATA);

  imem_loader_byte_assembler u_byte_assembler (
    .clk             (clk),
    .rst             (rst),
    .clear_i         (start_evt),
    .byte_valid_i    (asm_valid),
    .byte_i          (IN_DATA),
    .word_o          (asm_word),
    .word_complete_c (word_complete_c)
  );

  // Next state, counters and the registered view of every output.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    addr_d  = addr_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_evt) begin
          state_d = S_LEN_LO;
          len_d   = '0;
          cnt_d   = '0;
          csum_d  = CSUM_INIT;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d   = {8'h00, IN_DATA};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d = {IN_DATA, len_q[7:0]};
          if (len_d > MAX_WORDS) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else if (len_d == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          csum_d = csum_q ^ IN_DATA;
          if (word_complete_c) begin
            state_d = S_WRITE;
            addr_d  = ADDR_WIDTH'(cnt_q);
          end
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (LEN_W'(cnt_d) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (accept) begin
          if (IN_DATA == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = takes_byte(state_d);
    cen_d   = (state_d != S_WRITE);
    wen_d   = (state_d != S_WRITE);
    hold_d  = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= CSUM_INIT;
      addr_q  <= '0;
      ready_q <= 1'b0;
      cen_q   <= 1'b1;
      wen_q   <= 1'b1;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      cen_q   <= cen_d;
      wen_q   <= wen_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign IN_READY  = ready_q;
  assign MEM_CEN   = cen_q;
  assign MEM_WEN   = wen_q;
  assign MEM_A     = addr_q;
  assign MEM_D     = WIDTH'(asm_word);
  assign CORE_HOLD = hold_q;
  assign DONE      = done_q;
  assign ERROR     = err_q;

endmodule
